// File: rtl/key_cond_pkg.sv
// Shared types and DE2 board defaults for the pushbutton/switch front end.
package key_cond_pkg;

  // Reset-stretch controller states
  typedef enum logic [1:0] {
    HOLD_PRESS = 2'd0,
    HOLD_COUNT = 2'd1,
    RUN        = 2'd2
  } stretch_state_t;

  // DE2 board defaults
  localparam int unsigned CLOCK_HZ            = 50_000_000;
  localparam int unsigned DEF_NUM_KEYS        = 3;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500_000;  // 10 ms at CLOCK_HZ
  localparam int unsigned DEF_RESET_HOLD      = 16;
  localparam int unsigned DEF_STEP_KEY        = 1;
  localparam int unsigned DEF_RST_KEY         = 0;

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: two-flop synchronizer, debounce counter, clean level and
// one-cycle press/release pulses. Raw input is active-low; outputs active-high.
module key_debounce
  import key_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          pressed;
  logic [CW-1:0] count;

  // Two-flop synchronizer; resets to the released (high) level
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end

  assign pressed = ~sync2;

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES samples;
  // any sample matching the current level restarts the count
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count       <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      if (pressed == key_level) begin
        count <= '0;
      end else if (count == CW'(DEBOUNCE_CYCLES - 1)) begin
        count       <= '0;
        key_level   <= pressed;
        key_press   <= pressed;
        key_release <= ~pressed;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// DE2 front end: debounced keys, processor clock enable (free-run or
// single-step) and a stretched active-low processor reset.
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = DEF_NUM_KEYS,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned RESET_HOLD      = DEF_RESET_HOLD,
  parameter int unsigned STEP_KEY        = DEF_STEP_KEY,
  parameter int unsigned RST_KEY         = DEF_RST_KEY
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_raw,
  input  logic                sw_run,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                proc_en,
  output logic                proc_reset_n
);

  localparam int unsigned HW = $clog2(RESET_HOLD + 1);

  logic           sw_sync1;
  logic           sw_sync2;
  logic           en_reg;
  stretch_state_t state;
  logic [HW-1:0]  hold_count;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clock      (clock),
      .reset      (reset),
      .key_raw    (key_raw[i]),
      .key_level  (key_level[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i])
    );
  end

  // Two-flop synchronizer for the run/step switch
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sw_sync1 <= 1'b0;
      sw_sync2 <= 1'b0;
    end else begin
      sw_sync1 <= sw_run;
      sw_sync2 <= sw_sync1;
    end
  end

  // Enable register: continuous in free-run, one pulse per debounced step press
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      en_reg <= 1'b0;
    end else begin
      en_reg <= sw_sync2 | key_press[STEP_KEY];
    end
  end

  // Masking with the registered reset makes a reset press win over a
  // simultaneous step press and keeps the enable low for the whole hold
  assign proc_en = en_reg & proc_reset_n;

  // Reset-stretch controller; the reset key overrides every state.
  // The cycle in which the released key is first seen counts as the first
  // hold cycle, so the stretch lasts RESET_HOLD cycles after the level falls.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= HOLD_COUNT;
      hold_count   <= HW'(RESET_HOLD);
      proc_reset_n <= 1'b0;
    end else if (key_level[RST_KEY]) begin
      state        <= HOLD_PRESS;
      hold_count   <= HW'(RESET_HOLD);
      proc_reset_n <= 1'b0;
    end else begin
      case (state)
        HOLD_PRESS, HOLD_COUNT: begin
          if (hold_count == HW'(1)) begin
            state        <= RUN;
            proc_reset_n <= 1'b1;
          end else begin
            state        <= HOLD_COUNT;
            hold_count   <= hold_count - HW'(1);
            proc_reset_n <= 1'b0;
          end
        end
        RUN: begin
          proc_reset_n <= 1'b1;
        end
        default: begin
          state        <= HOLD_COUNT;
          hold_count   <= HW'(RESET_HOLD);
          proc_reset_n <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: output events are predicted into a
// scoreboard when stimulus is driven and matched as the DUT produces them.
module tb_key_conditioner;

  localparam int unsigned NK      = 3;
  localparam int unsigned DB      = 4;
  localparam int unsigned RH      = 3;
  localparam int unsigned RH_LONG = 10;

  // Event codes (key index added for per-key events)
  localparam int EV_LUP = 16;
  localparam int EV_LDN = 32;
  localparam int EV_PRS = 48;
  localparam int EV_REL = 64;
  localparam int EV_RUP = 80;
  localparam int EV_RDN = 96;
  localparam int EV_EUP = 112;
  localparam int EV_EDN = 128;

  logic          clock = 1'b0;
  logic          reset;
  logic          sw_run;
  logic [NK-1:0] key_raw;
  logic [NK-1:0] key_level, key_press, key_release;
  logic          proc_en, proc_reset_n;
  logic [NK-1:0] l_level, l_press, l_release;
  logic          l_en, l_rstn;

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  longint      sb[$];

  logic [NK-1:0] prev_level;
  logic          prev_rstn, prev_en;

  key_conditioner #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .RESET_HOLD(RH), .STEP_KEY(1), .RST_KEY(0)
  ) dut (
    .clock(clock), .reset(reset), .key_raw(key_raw), .sw_run(sw_run),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .proc_en(proc_en), .proc_reset_n(proc_reset_n)
  );

  // Longer hold so a re-press can land inside the hold count
  key_conditioner #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .RESET_HOLD(RH_LONG), .STEP_KEY(1), .RST_KEY(0)
  ) dut_long (
    .clock(clock), .reset(reset), .key_raw(key_raw), .sw_run(sw_run),
    .key_level(l_level), .key_press(l_press), .key_release(l_release),
    .proc_en(l_en), .proc_reset_n(l_rstn)
  );

  always #10 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int unsigned at, input int code);
    sb.push_back(longint'(at) * 256 + longint'(code));
  endtask

  task automatic observe(input int code);
    longint ev;
    longint exp_ev;
    ev = longint'(cyc) * 256 + longint'(code);
    if (sb.size() == 0) begin
      check_eq("unexpected_event", ev, 0);
    end else begin
      exp_ev = sb.pop_front();
      check_eq("event", ev, exp_ev);
    end
  endtask

  task automatic wait_until(input int unsigned c);
    while (cyc < c) begin
      @(posedge clock);
      #2;
    end
  endtask

  // Event monitor, sampled mid-cycle
  always @(negedge clock) begin
    if (!reset) begin
      prev_level = key_level;
      prev_rstn  = proc_reset_n;
      prev_en    = proc_en;
    end else begin
      for (int k = 0; k < NK; k++) begin
        if (key_level[k] != prev_level[k]) observe((key_level[k] ? EV_LUP : EV_LDN) + k);
        if (key_press[k]) observe(EV_PRS + k);
        if (key_release[k]) observe(EV_REL + k);
      end
      if (proc_reset_n != prev_rstn) observe(proc_reset_n ? EV_RUP : EV_RDN);
      if (proc_en != prev_en) observe(proc_en ? EV_EUP : EV_EDN);
      prev_level = key_level;
      prev_rstn  = proc_reset_n;
      prev_en    = proc_en;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n, p, a, d;

    // Global reset
    reset = 1'b1; key_raw = '1; sw_run = 1'b0;
    #1 reset = 1'b0;
    #1;
    check_eq("rst_level", key_level, 0);
    check_eq("rst_press", key_press, 0);
    check_eq("rst_release", key_release, 0);
    check_eq("rst_en", proc_en, 0);
    check_eq("rst_rstn", proc_reset_n, 0);
    wait_until(2);
    check_eq("rstn_in_reset", proc_reset_n, 0);
    n = cyc; reset = 1'b1;
    expect_ev(n + 3, EV_RUP);
    wait_until(n + 2);
    check_eq("rstn_before_hold", proc_reset_n, 0);
    wait_until(n + 3);
    check_eq("rstn_after_hold", proc_reset_n, 1);
    wait_until(n + 14);
    check_eq("idle_level", key_level, 0);

    // Clean press / release on key 2
    n = cyc; key_raw[2] = 1'b0;
    expect_ev(n + 6, EV_LUP + 2); expect_ev(n + 6, EV_PRS + 2);
    wait_until(n + 5);
    check_eq("level_not_early", key_level[2], 0);
    wait_until(n + 6);
    check_eq("level_pressed", key_level[2], 1);
    wait_until(n + 12);
    n = cyc; key_raw[2] = 1'b1;
    expect_ev(n + 6, EV_LDN + 2); expect_ev(n + 6, EV_REL + 2);
    wait_until(n + 10);
    check_eq("drain_clean", sb.size(), 0);

    // Glitch rejection: low 3, high 1, low 10
    n = cyc; key_raw[2] = 1'b0;
    wait_until(n + 3); key_raw[2] = 1'b1;
    wait_until(n + 4); key_raw[2] = 1'b0;
    expect_ev(n + 10, EV_LUP + 2); expect_ev(n + 10, EV_PRS + 2);
    wait_until(n + 9);
    check_eq("glitch_not_early", key_level[2], 0);
    wait_until(n + 14); key_raw[2] = 1'b1;
    expect_ev(n + 20, EV_LDN + 2); expect_ev(n + 20, EV_REL + 2);
    wait_until(n + 24);
    check_eq("drain_glitch", sb.size(), 0);

    // Single-step: three held presses of key 1
    for (int i = 0; i < 3; i++) begin
      n = cyc; key_raw[1] = 1'b0;
      expect_ev(n + 6, EV_LUP + 1); expect_ev(n + 6, EV_PRS + 1);
      expect_ev(n + 7, EV_EUP); expect_ev(n + 8, EV_EDN);
      wait_until(n + 7);
      check_eq("step_pulse", proc_en, 1);
      wait_until(n + 20); key_raw[1] = 1'b1;
      expect_ev(n + 26, EV_LDN + 1); expect_ev(n + 26, EV_REL + 1);
      wait_until(n + 32);
    end
    check_eq("drain_step", sb.size(), 0);

    // Free-run
    n = cyc; sw_run = 1'b1;
    expect_ev(n + 3, EV_EUP);
    wait_until(n + 2);
    check_eq("run_not_early", proc_en, 0);
    wait_until(n + 8);
    check_eq("run_enabled", proc_en, 1);
    check_eq("drain_run", sb.size(), 0);

    // Processor reset with re-press
    p = cyc; key_raw[0] = 1'b0;
    expect_ev(p + 6, EV_LUP + 0); expect_ev(p + 6, EV_PRS + 0);
    expect_ev(p + 7, EV_RDN); expect_ev(p + 7, EV_EDN);
    wait_until(p + 10); key_raw[0] = 1'b1;
    expect_ev(p + 16, EV_LDN + 0); expect_ev(p + 16, EV_REL + 0);
    expect_ev(p + 19, EV_RUP); expect_ev(p + 19, EV_EUP);
    wait_until(p + 14); key_raw[0] = 1'b0;
    expect_ev(p + 20, EV_LUP + 0); expect_ev(p + 20, EV_PRS + 0);
    expect_ev(p + 21, EV_RDN); expect_ev(p + 21, EV_EDN);
    wait_until(p + 24); key_raw[0] = 1'b1;
    expect_ev(p + 30, EV_LDN + 0); expect_ev(p + 30, EV_REL + 0);
    expect_ev(p + 33, EV_RUP); expect_ev(p + 33, EV_EUP);
    wait_until(p + 26);
    check_eq("long_repress_hold", l_rstn, 0);
    wait_until(p + 32);
    check_eq("rstn_still_held", proc_reset_n, 0);
    wait_until(p + 39);
    check_eq("long_count_restart", l_rstn, 0);
    wait_until(p + 40);
    check_eq("long_release", l_rstn, 1);
    wait_until(p + 42);
    check_eq("drain_procrst", sb.size(), 0);

    // Reset key and step key pressed together in single-step mode
    n = cyc; sw_run = 1'b0;
    expect_ev(n + 3, EV_EDN);
    wait_until(n + 6);
    n = cyc; key_raw[1:0] = 2'b00;
    expect_ev(n + 6, EV_LUP + 0); expect_ev(n + 6, EV_PRS + 0);
    expect_ev(n + 6, EV_LUP + 1); expect_ev(n + 6, EV_PRS + 1);
    expect_ev(n + 7, EV_RDN);
    wait_until(n + 7);
    check_eq("reset_beats_step", proc_en, 0);
    wait_until(n + 10); key_raw[1:0] = 2'b11;
    expect_ev(n + 16, EV_LDN + 0); expect_ev(n + 16, EV_REL + 0);
    expect_ev(n + 16, EV_LDN + 1); expect_ev(n + 16, EV_REL + 1);
    expect_ev(n + 19, EV_RUP);
    wait_until(n + 25);
    check_eq("drain_simul", sb.size(), 0);

    // Asynchronous reset mid-debounce
    a = cyc; key_raw[1] = 1'b0;
    wait_until(a + 4);
    #5 reset = 1'b0;
    #1;
    check_eq("async_rstn", proc_reset_n, 0);
    check_eq("async_en", proc_en, 0);
    check_eq("async_level", key_level, 0);
    check_eq("async_press", key_press, 0);
    key_raw[1] = 1'b1;
    wait_until(a + 6);
    d = cyc; reset = 1'b1;
    expect_ev(d + 3, EV_RUP);
    wait_until(d + 15);
    check_eq("post_reset_level", key_level, 0);
    check_eq("post_reset_en", proc_en, 0);
    check_eq("drain_final", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
